// File: rtl/truth_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_sweep_pkg
// Description : Shared types and sizing helpers for the truth-table sweep
//               controller and its settle timer.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_sweep_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  // Default sizing for a 4-input function block
  localparam int N_IN_DEF  = 4;
  localparam int TBL_W_DEF = 1 << N_IN_DEF;
  localparam int CNT_W_DEF = N_IN_DEF + 1;

  // Settle counter width: SETTLE is limited to 1..15
  localparam int SETTLE_W = 4;

  // Truth table width for an n-input function
  function automatic int tbl_width(input int n);
    return 1 << n;
  endfunction

  // Mismatch counter width; one extra bit so an all-mismatch sweep fits
  function automatic int cnt_width(input int n);
    return n + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : sweep_settle_timer
// Description : Loadable up-counter that flags the last settle cycle
//               (count == SETTLE-1) of each held input code.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_settle_timer
  import truth_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic term
);

  logic [SETTLE_W-1:0] count;

  // Clear has priority so a fresh code always starts its settle window at 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + SETTLE_W'(1);
    end
  end

  // Terminal flag: this is the last cycle the code must be held before sampling
  always_comb begin
    term = (count == SETTLE_W'(SETTLE - 1));
  end

endmodule
`default_nettype wire

// File: rtl/truth_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : truth_sweep_ctrl
// Description : Drives every input code onto a combinational function block,
//               samples its output after a settle interval, builds the
//               measured truth table and compares it to a latched reference.
//               SETTLE must lie in 1..15.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_sweep_ctrl
  import truth_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  expected,
  output logic [N_IN-1:0]       abcd_out,
  input  logic                  y_in,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<N_IN)-1:0]  truth,
  output logic                  match,
  output logic [N_IN:0]         mismatch_cnt,
  output logic [N_IN-1:0]       first_fail
);

  localparam int TBL_W = tbl_width(N_IN);
  localparam int CNT_W = cnt_width(N_IN);
  localparam logic [N_IN-1:0] LAST_CODE = {N_IN{1'b1}};

  sweep_state_t     state;
  logic [TBL_W-1:0] exp_q;
  logic             tmr_clear;
  logic             tmr_inc;
  logic             tmr_term;
  logic             accept;
  logic             miss;
  logic [TBL_W-1:0] truth_nxt;

  // A start is only honoured when no sweep is running
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    tmr_clear = accept || (state == SAMPLE);
    tmr_inc   = (state == WAIT);
  end

  // Sample-time comparison and table update for the current code
  always_comb begin
    truth_nxt           = truth;
    truth_nxt[abcd_out] = y_in;
    miss                = y_in ^ exp_q[abcd_out];
  end

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .inc   (tmr_inc),
    .term  (tmr_term)
  );

  // Sweep sequencer with registered outputs and result accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      abcd_out     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth        <= '0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      exp_q        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            exp_q        <= expected;
            truth        <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            match        <= 1'b0;
            abcd_out     <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (tmr_term) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          truth <= truth_nxt;
          if (miss) begin
            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (mismatch_cnt == '0) begin
              first_fail <= abcd_out;
            end
          end
          if (abcd_out == LAST_CODE) begin
            // Final code: hold abcd_out at the top code and publish the verdict
            busy  <= 1'b0;
            done  <= 1'b1;
            match <= (truth_nxt == exp_q);
            state <= DONE;
          end else begin
            abcd_out <= abcd_out + N_IN'(1);
            state    <= WAIT;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_truth_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_sweep_ctrl
// Description : Scoreboard bench for truth_sweep_ctrl with SETTLE=1 and
//               SETTLE=3 instances, each wrapped around a Y2 function block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_sweep_ctrl;

  typedef struct {
    logic [15:0] truth;
    logic        match;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    int          done_cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [15:0] exp1 = '0;
  logic [15:0] exp3 = '0;
  logic        tie_one = 1'b0;
  int          cyc = 0;

  logic [3:0]  abcd1, abcd3;
  logic        busy1, busy3, done1, done3, match1, match3;
  logic [15:0] truth1, truth3;
  logic [4:0]  cnt1, cnt3;
  logic [3:0]  ff1, ff3;
  logic        y1, y3;

  int n_total = 0;
  int n_bad   = 0;
  res_t q1[$];
  res_t q3[$];
  logic pd1 = 1'b0;
  logic pd3 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Y2 function block: sum of minterms 4,5,6,7,11,12,13 (A = MSB)
  function automatic logic y2(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (~a & b) | (a & ~b & c & d) | (a & b & ~c);
  endfunction

  assign y1 = tie_one ? 1'b1 : y2(abcd1);
  assign y3 = tie_one ? 1'b1 : y2(abcd3);

  truth_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1),
    .abcd_out(abcd1), .y_in(y1), .busy(busy1), .done(done1),
    .truth(truth1), .match(match1), .mismatch_cnt(cnt1), .first_fail(ff1)
  );

  truth_sweep_ctrl #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3),
    .abcd_out(abcd3), .y_in(y3), .busy(busy3), .done(done3),
    .truth(truth3), .match(match3), .mismatch_cnt(cnt3), .first_fail(ff3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // Reference result, independent of the DUT: the Y2 table is 16'h38F0
  function automatic res_t model(input logic [15:0] ex, input logic one,
                                 input int e0, input int settle);
    res_t r;
    logic [15:0] x;
    r.truth = one ? 16'hFFFF : 16'h38F0;
    x = r.truth ^ ex;
    r.cnt = '0;
    r.ff  = '0;
    for (int k = 15; k >= 0; k--) begin
      if (x[k]) begin
        r.cnt = r.cnt + 5'd1;
        r.ff  = 4'(k);
      end
    end
    r.match    = (x == 16'h0);
    r.done_cyc = e0 + 16 * (settle + 1);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; scramble expected afterwards to prove it is latched
  task automatic pulse_start(input int which, input logic [15:0] ex);
    if (which == 1) begin
      exp1 = ex; start1 = 1'b1;
      q1.push_back(model(ex, tie_one, cyc + 1, 1));
      step();
      start1 = 1'b0; exp1 = 16'($urandom);
    end else begin
      exp3 = ex; start3 = 1'b1;
      q3.push_back(model(ex, tie_one, cyc + 1, 3));
      step();
      start3 = 1'b0; exp3 = 16'($urandom);
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < bound) begin
      step();
      n++;
    end
    if (q1.size() != 0 || q3.size() != 0) begin
      check_eq("timeout", 32'(q1.size() + q3.size()), 32'd0);
      q1.delete();
      q3.delete();
    end
  endtask

  task automatic check_zero1(input string tag);
    check_eq({tag, "_abcd"},  32'(abcd1),  32'd0);
    check_eq({tag, "_busy"},  32'(busy1),  32'd0);
    check_eq({tag, "_done"},  32'(done1),  32'd0);
    check_eq({tag, "_truth"}, 32'(truth1), 32'd0);
    check_eq({tag, "_match"}, 32'(match1), 32'd0);
    check_eq({tag, "_cnt"},   32'(cnt1),   32'd0);
    check_eq({tag, "_ff"},    32'(ff1),    32'd0);
  endtask

  // Scoreboard: pop and compare on each rising edge of done
  always @(negedge clk) begin
    res_t r;
    if (done1 && !pd1) begin
      if (q1.size() == 0) check_eq("s1_spurious_done", 32'd1, 32'd0);
      else begin
        r = q1.pop_front();
        check_eq("s1_done_cyc", 32'(cyc), 32'(r.done_cyc));
        check_eq("s1_truth", 32'(truth1), 32'(r.truth));
        check_eq("s1_match", 32'(match1), 32'(r.match));
        check_eq("s1_cnt",   32'(cnt1),   32'(r.cnt));
        check_eq("s1_ff",    32'(ff1),    32'(r.ff));
        check_eq("s1_busy",  32'(busy1),  32'd0);
        check_eq("s1_abcd",  32'(abcd1),  32'd15);
      end
    end
    if (done3 && !pd3) begin
      if (q3.size() == 0) check_eq("s3_spurious_done", 32'd1, 32'd0);
      else begin
        r = q3.pop_front();
        check_eq("s3_done_cyc", 32'(cyc), 32'(r.done_cyc));
        check_eq("s3_truth", 32'(truth3), 32'(r.truth));
        check_eq("s3_match", 32'(match3), 32'(r.match));
        check_eq("s3_cnt",   32'(cnt3),   32'(r.cnt));
        check_eq("s3_ff",    32'(ff3),    32'(r.ff));
      end
    end
    pd1 <= done1;
    pd3 <= done3;
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    step(); step();
    check_zero1("rst");
    check_eq("rst_s3_busy", 32'(busy3), 32'd0);
    rst_n = 1'b1;
    step();

    // Matching sweep, single mismatch at code 0, all-mismatch with y tied high
    pulse_start(1, 16'h38F0);
    check_eq("s1_busy_rise", 32'(busy1), 32'd1);
    wait_done(100);
    pulse_start(1, 16'h38F1);
    wait_done(100);
    tie_one = 1'b1;
    pulse_start(1, 16'h0000);
    wait_done(100);
    tie_one = 1'b0;

    // SETTLE=3: each code held 4 cycles, start at cycle 10 ignored
    pulse_start(3, 16'h38F0);
    repeat (3) step();
    check_eq("s3_hold_t3", 32'(abcd3), 32'd0);
    step();
    check_eq("s3_hold_t4", 32'(abcd3), 32'd1);
    repeat (3) step();
    check_eq("s3_hold_t7", 32'(abcd3), 32'd1);
    step();
    check_eq("s3_hold_t8", 32'(abcd3), 32'd2);
    step();
    start3 = 1'b1; exp3 = 16'hFFFF;
    step();
    start3 = 1'b0;
    check_eq("s3_busy_ignore", 32'(busy3), 32'd1);
    wait_done(150);

    // Reset in the middle of a sweep
    pulse_start(1, 16'h38F0);
    repeat (11) step();
    check_eq("mid_busy", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    q1.delete();
    step();
    check_zero1("midrst");
    rst_n = 1'b1;
    step();
    pulse_start(1, 16'h38F0);
    wait_done(100);

    // Restart from DONE: done drops and truth clears at the accepting edge
    pulse_start(1, 16'h38F0);
    check_eq("restart_done",  32'(done1),  32'd0);
    check_eq("restart_truth", 32'(truth1), 32'd0);
    check_eq("restart_busy",  32'(busy1),  32'd1);
    wait_done(100);

    step(); step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/truth_sweep_ctrl.md
Name: truth_sweep_ctrl

Overview:
- Sequential sweep controller that sits directly around our 4-input combinational function blocks (the Y-style sum-of-minterm modules).
- Upstream role: drives every input code 0..2^N_IN-1 onto the function block's inputs.
- Downstream role: samples the block's single-bit output after a settle interval and assembles the measured truth table.
- On completion, compares the measured table against a supplied expected table and reports match, mismatch count and first failing code. Replaces free-running `$stop`-based sweeps with a synthesizable, restartable checker.

Parameters:
- N_IN, 4, number of function inputs; the truth table has 2^N_IN entries.
- SETTLE, 1, cycles the code is held before sampling; legal range 1..15 (0 is illegal).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request to begin a sweep
- expected  input  2^N_IN  reference truth table, bit k = expected output for code k; latched when start is accepted
- abcd_out  output  N_IN  code driven to the function block, MSB = A
- y_in  input  1  function block output
- busy  output  1  sweep in progress
- done  output  1  sweep finished; held until the next accepted start or reset
- truth  output  2^N_IN  measured table, bit k = y_in sampled for code k
- match  output  1  truth == latched expected; meaningful only while done=1
- mismatch_cnt  output  N_IN+1  number of differing bits, 0..2^N_IN
- first_fail  output  N_IN  lowest code that mismatched; 0 if none

Behaviour:
- Reset: reset is synchronous and active-low; the clock is clk and the reset is rst_n. When rst_n=0 at a rising edge, all state clears: state=IDLE, abcd_out=0, busy=0, done=0, truth=0, match=0, mismatch_cnt=0, first_fail=0, settle counter=0, latched expected=0.
- Mid-sweep reset: reset during a sweep aborts it with the same clearing; no partial result is retained.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 at edge E0 latches expected, clears truth, mismatch_cnt and first_fail, sets abcd_out=0 and busy=1, and moves to WAIT with settle counter=0.
- WAIT:
  - Settle counter increments each cycle.
  - When counter==SETTLE-1, move to SAMPLE.
  - abcd_out is held stable.
- SAMPLE (one cycle):
  - At the edge leaving SAMPLE, write truth[abcd_out] <= y_in.
  - If y_in != expected[abcd_out]: mismatch_cnt += 1, and first_fail <= abcd_out if this is the first mismatch.
  - If abcd_out == 2^N_IN-1, go to DONE. Otherwise abcd_out += 1 and return to WAIT with counter=0.
- Timing:
  - Each code occupies exactly SETTLE+1 cycles.
  - Code k is captured at edge E0+(k+1)(SETTLE+1).
  - done rises, busy falls and match is registered at edge E0+2^N_IN*(SETTLE+1). For the defaults this is 32 cycles.
- DONE:
  - abcd_out stays at 2^N_IN-1.
  - done=1 and the results are held.
  - start=1 restarts exactly as from IDLE; done drops at that edge.
- start while busy=1 is ignored: no restart and no effect on results.
- abcd_out never wraps inside a sweep; incrementing past the maximum code is impossible by construction.
- mismatch_cnt is N_IN+1 bits wide so an all-mismatch sweep (2^N_IN) cannot overflow.
- y_in is sampled only in SAMPLE; glitches during WAIT are irrelevant.
- expected may change freely after start is accepted without affecting the result.

Decomposition:
- Package truth_sweep_pkg:
  - state enum {IDLE, WAIT, SAMPLE, DONE}
  - localparams for the table width (2^N_IN) and the count width (N_IN+1)
- One natural sub-module, sweep_settle_timer: a loadable up-counter with a terminal flag at SETTLE-1.
- The function block under test is instantiated beside the controller in the testbench, never inside it.

Test Plan:
- Y2 function, expected=16'h38F0, SETTLE=1, pulse start → done at start+32 cycles, truth=16'h38F0, match=1, mismatch_cnt=0, first_fail=0.
- Same DUT, expected=16'h38F1 → truth=16'h38F0, match=0, mismatch_cnt=1, first_fail=0.
- y_in tied to 1, expected=16'h0000 → mismatch_cnt=16, first_fail=0, truth=16'hFFFF.
- SETTLE=3, pulse start → abcd_out holds each code for 4 cycles, done at start+64 cycles; a second start pulse at cycle 10 is ignored.
- rst_n=0 at cycle 12 of a sweep → next cycle all outputs are 0 and state is IDLE; a new start then completes normally with truth=16'h38F0.
- Start issued in DONE → done drops at that edge and truth clears to 0; the sweep repeats with identical results.
